// File: rtl/sample_sum_pkg.sv
// Shared definitions for the sample-sum scheduler: FSM states and the
// integration wait length derived from the summer configuration.
package sample_sum_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INTEGRATE,
    READOUT
  } state_t;

  function automatic int unsigned wait_cycles(input int unsigned presample_num,
                                              input int unsigned sample_num);
    return presample_num + sample_num + 3;
  endfunction

endpackage

// File: rtl/ch_next_sel.sv
// Masked channel search: returns the lowest unmasked index above cur (or from 0
// when from_start is set) and whether no further unmasked channel follows it.
module ch_next_sel #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] mask,
  input  logic [CH_W-1:0] cur,
  input  logic            from_start,
  output logic [CH_W-1:0] nxt,
  output logic            found,
  output logic            last
);

  always_comb begin
    nxt   = '0;
    found = 1'b0;
    last  = 1'b1;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (mask[i] && (from_start || (i > 32'(cur)))) begin
        if (!found) begin
          nxt   = CH_W'(i);
          found = 1'b1;
        end else begin
          last = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sample_sum_sched.sv
// Sequences an L0 trigger to all channel summers, waits out the integration
// window, captures every channel result and reads out the unmasked ones.
module sample_sum_sched
  import sample_sum_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int PRESAMPLE_NUM = 8,
  parameter int SAMPLE_NUM    = 16,
  parameter int DATA_W        = 12,
  localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     l0_in,
  input  logic                     enable,
  input  logic [N_CH-1:0]          ch_mask,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  output logic                     l0_out,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_last,
  output logic [15:0]              evt_cnt,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned WAIT   = wait_cycles(PRESAMPLE_NUM, SAMPLE_NUM);
  localparam int          WAIT_W = $clog2(WAIT + 1);

  state_t              state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [DATA_W-1:0]   cap    [N_CH];
  logic [DATA_W-1:0]   ch_arr [N_CH];
  logic [N_CH-1:0]     mask_q;
  logic                in_integ;
  logic [N_CH-1:0]     sel_mask;
  logic [CH_W-1:0]     sel_nxt;
  logic                sel_found;
  logic                sel_last;

  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      ch_arr[i] = ch_data[i*DATA_W +: DATA_W];
    end
  end

  // During INTEGRATE the selector looks at the live mask to pick the first
  // word at capture; afterwards it walks the captured mask from out_ch.
  assign in_integ = (state == INTEGRATE);
  assign sel_mask = in_integ ? ch_mask : mask_q;

  ch_next_sel #(
    .N_CH(N_CH),
    .CH_W(CH_W)
  ) u_sel (
    .mask      (sel_mask),
    .cur       (out_ch),
    .from_start(in_integ),
    .nxt       (sel_nxt),
    .found     (sel_found),
    .last      (sel_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      l0_out    <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      evt_cnt   <= '0;
      drop_cnt  <= '0;
      wait_cnt  <= '0;
      mask_q    <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        cap[i] <= '0;
      end
    end else begin
      l0_out <= 1'b0;
      if (l0_in && !(state == IDLE && enable) && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      case (state)
        IDLE: begin
          if (l0_in && enable) begin
            l0_out   <= 1'b1;
            evt_cnt  <= evt_cnt + 16'd1;
            wait_cnt <= WAIT_W'(WAIT);
            state    <= INTEGRATE;
            busy     <= 1'b1;
          end
        end
        INTEGRATE: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == WAIT_W'(1)) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
              cap[i] <= ch_arr[i];
            end
            mask_q <= ch_mask;
            if (sel_found) begin
              state     <= READOUT;
              out_valid <= 1'b1;
              out_ch    <= sel_nxt;
              out_data  <= ch_arr[sel_nxt];
              out_last  <= sel_last;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        READOUT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_ch   <= sel_nxt;
              out_data <= cap[sel_nxt];
              out_last <= sel_last;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_sum_sched.sv
// Self-checking bench for sample_sum_sched: directed scenarios plus random
// events compared against a per-event word list built from mask and data.
module tb_sample_sum_sched;

  localparam int N_CH  = 4;
  localparam int PRE   = 8;
  localparam int SMP   = 16;
  localparam int DW    = 12;
  localparam int WAITC = PRE + SMP + 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 l0_in;
  logic                 enable;
  logic [N_CH-1:0]      ch_mask;
  logic [N_CH*DW-1:0]   ch_data;
  logic                 l0_out;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic [1:0]           out_ch;
  logic                 out_last;
  logic [15:0]          evt_cnt;
  logic [15:0]          drop_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_evt  = 0;
  int exp_drop = 0;

  always #5 clk = ~clk;

  sample_sum_sched #(
    .N_CH         (N_CH),
    .PRESAMPLE_NUM(PRE),
    .SAMPLE_NUM   (SMP),
    .DATA_W       (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .l0_in    (l0_in),
    .enable   (enable),
    .ch_mask  (ch_mask),
    .ch_data  (ch_data),
    .l0_out   (l0_out),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_last (out_last),
    .evt_cnt  (evt_cnt),
    .drop_cnt (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_evt"}, 32'(evt_cnt), 32'(exp_evt & 16'hFFFF));
    chk({tag, "_drop"}, 32'(drop_cnt), 32'((exp_drop > 16'hFFFF) ? 16'hFFFF : exp_drop));
  endtask

  // One complete event: trigger, integration window, readout of unmasked words.
  task automatic run_event(input logic [N_CH-1:0] m, input logic [N_CH*DW-1:0] d,
                           input int ready_pct, input bit drop_at_last,
                           input bit extra_trig, input bit enable_off);
    logic [DW-1:0] cap [N_CH];
    int            exp_ch[$];
    int            n;
    int            guard;
    bit            stalled;
    bit            saw_valid;
    logic [DW-1:0] hd;
    logic [1:0]    hc;
    logic          hl;

    for (int i = 0; i < N_CH; i++) begin
      cap[i] = d[i*DW +: DW];
      if (m[i]) exp_ch.push_back(i);
    end
    ch_data   = d;
    ch_mask   = m;
    enable    = 1'b1;
    out_ready = 1'b0;
    l0_in     = 1'b1;
    tick();
    l0_in = 1'b0;
    exp_evt++;
    chk("l0_out_pulse", 32'(l0_out), 32'd1);
    chk("busy_on_trigger", 32'(busy), 32'd1);
    chk_counts("after_trigger");
    if (enable_off) enable = 1'b0;

    n = 0;
    saw_valid = 1'b0;
    while (!out_valid && n < WAITC + 5) begin
      if (extra_trig && n == 5) begin
        l0_in = 1'b1;
        exp_drop++;
      end
      tick();
      l0_in = 1'b0;
      n++;
      chk("l0_out_single", 32'(l0_out), 32'd0);
      if (m == '0) begin
        chk("busy_window", 32'(busy), 32'(n < WAITC));
        if (n == WAITC) break;
      end else if (!out_valid) begin
        chk("busy_integrate", 32'(busy), 32'd1);
      end
      if (out_valid) saw_valid = 1'b1;
    end

    if (m == '0) begin
      chk("no_valid_empty_mask", 32'(saw_valid | out_valid), 32'd0);
      chk_counts("empty_mask");
      enable = 1'b1;
      return;
    end

    chk("capture_latency", 32'(n), 32'(WAITC));
    // Inputs changing after capture must not disturb this event.
    ch_data = {$urandom, $urandom};
    ch_mask = N_CH'($urandom);

    stalled = 1'b0;
    guard   = 0;
    while (exp_ch.size() > 0 && guard < 200) begin
      guard++;
      if (!out_valid) begin
        chk("valid_during_readout", 32'(out_valid), 32'd1);
        break;
      end
      if (stalled) begin
        chk("stall_data", 32'(out_data), 32'(hd));
        chk("stall_ch", 32'(out_ch), 32'(hc));
        chk("stall_last", 32'(out_last), 32'(hl));
      end
      out_ready = ($urandom_range(99) < ready_pct);
      if (out_ready) begin
        chk("word_ch", 32'(out_ch), 32'(exp_ch[0]));
        chk("word_data", 32'(out_data), 32'(cap[exp_ch[0]]));
        chk("word_last", 32'(out_last), 32'(exp_ch.size() == 1));
        if (exp_ch.size() == 1 && drop_at_last) begin
          l0_in = 1'b1;
          exp_drop++;
        end
        void'(exp_ch.pop_front());
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        hd = out_data;
        hc = out_ch;
        hl = out_last;
      end
      tick();
      l0_in = 1'b0;
    end
    out_ready = 1'b0;
    chk("words_remaining", 32'(exp_ch.size()), 32'd0);
    chk("busy_after_last", 32'(busy), 32'd0);
    chk("valid_after_last", 32'(out_valid), 32'd0);
    if (drop_at_last) chk("no_l0_out_on_final_drop", 32'(l0_out), 32'd0);
    chk_counts("event_end");
    enable = 1'b1;
  endtask

  initial begin
    logic [N_CH*DW-1:0] d;
    int n;

    rst       = 1'b1;
    l0_in     = 1'b0;
    enable    = 1'b1;
    ch_mask   = '0;
    ch_data   = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_l0_out", 32'(l0_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    chk_counts("rst");
    @(negedge clk);
    rst = 1'b0;

    // Full mask, fixed data 10/20/30/40, always ready.
    d = {12'd40, 12'd30, 12'd20, 12'd10};
    run_event(4'b1111, d, 100, 1'b0, 1'b0, 1'b0);

    // Sparse mask with a stalling consumer.
    d = {$urandom, $urandom};
    run_event(4'b1010, d, 50, 1'b0, 1'b0, 1'b0);

    // Empty mask: window only, no words.
    run_event(4'b0000, d, 100, 1'b0, 1'b0, 1'b0);

    // Trigger during integration is dropped; enable drop mid-event is harmless.
    d = {$urandom, $urandom};
    run_event(4'b0110, d, 100, 1'b0, 1'b1, 1'b1);

    // Trigger in IDLE while disabled.
    enable = 1'b0;
    l0_in  = 1'b1;
    tick();
    l0_in = 1'b0;
    exp_drop++;
    chk("disabled_no_l0_out", 32'(l0_out), 32'd0);
    chk("disabled_not_busy", 32'(busy), 32'd0);
    chk_counts("disabled_trigger");
    enable = 1'b1;

    // Random events; some collide a trigger with the final transfer, and the
    // next event then triggers in the first IDLE cycle.
    for (int k = 0; k < 8; k++) begin
      d = {$urandom, $urandom};
      run_event(N_CH'($urandom), d, 40 + 10 * (k % 6), (k % 2) == 1, (k % 3) == 0, 1'b0);
    end

    // Reset during readout after two transferred words.
    d = {$urandom, $urandom};
    ch_data = d;
    ch_mask = 4'b1111;
    l0_in   = 1'b1;
    tick();
    l0_in = 1'b0;
    n = 0;
    while (!out_valid && n < WAITC + 5) begin
      tick();
      n++;
    end
    chk("rst_case_latency", 32'(n), 32'(WAITC));
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    chk("rst_case_mid_readout", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_ch", 32'(out_ch), 32'd0);
    exp_evt  = 0;
    exp_drop = 0;
    chk_counts("mid_rst");
    tick();
    rst = 1'b0;
    d = {$urandom, $urandom};
    run_event(4'b1001, d, 100, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample_sum_sched.md
SAMPLE_SUM_SCHED -- requirements
Module: sample_sum_sched

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of sample-sum channels sequenced.
REQ-002 SHALL have parameter PRESAMPLE_NUM, default 8: presample count configured in every channel summer.
REQ-003 SHALL have parameter SAMPLE_NUM, default 16: sample count configured in every channel summer.
REQ-004 SHALL have parameter DATA_W, default 12: channel result width.
REQ-005 SHALL have port clk, input, 1: single clock.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port l0_in, input, 1: external L0 trigger, one-cycle pulse.
REQ-008 SHALL have port enable, input, 1: accept new triggers when 1.
REQ-009 SHALL have port ch_mask, input, N_CH: 1 = channel included in readout.
REQ-010 SHALL have port ch_data, input, N_CH x DATA_W: channel summer results.
REQ-011 SHALL have port l0_out, output, 1: start pulse broadcast to all summers.
REQ-012 SHALL have port busy, output, 1: 1 when not in IDLE.
REQ-013 SHALL have port out_valid, output, 1: readout word valid.
REQ-014 SHALL have port out_ready, input, 1: downstream accept.
REQ-015 SHALL have port out_data, output, DATA_W: captured channel result.
REQ-016 SHALL have port out_ch, output, clog2(N_CH): channel index of out_data.
REQ-017 SHALL have port out_last, output, 1: last word of the event.
REQ-018 SHALL have port evt_cnt, output, 16: accepted-trigger count, wraps at 0xFFFF to 0.
REQ-019 SHALL have port drop_cnt, output, 16: rejected-trigger count, saturates at 0xFFFF.

Function
REQ-020 SHALL implement the states IDLE, INTEGRATE and READOUT.
REQ-021 In IDLE, a cycle with l0_in=1 and enable=1 SHALL assert l0_out for exactly one cycle, increment evt_cnt, load the wait counter with WAIT = PRESAMPLE_NUM+SAMPLE_NUM+3, and enter INTEGRATE.
REQ-022 Any l0_in=1 outside IDLE, or in IDLE with enable=0, SHALL increment drop_cnt (saturating) and SHALL NOT produce l0_out.
REQ-023 INTEGRATE SHALL decrement the wait counter once per cycle; at the cycle it reaches 0, all ch_data SHALL be captured into internal registers and the FSM SHALL leave INTEGRATE.
REQ-024 At capture, if ch_mask is nonzero the FSM SHALL enter READOUT; if ch_mask is all zero it SHALL return to IDLE with no output words.
REQ-025 ch_mask SHALL be sampled at capture; later changes SHALL NOT affect the event being read out.
REQ-026 READOUT SHALL emit one word per unmasked channel, in ascending index order, with out_data equal to the captured value and out_ch equal to the index.
REQ-027 out_valid/out_data/out_ch/out_last SHALL be held stable while out_valid=1 and out_ready=0; a word SHALL transfer on a cycle with out_valid=1 and out_ready=1.
REQ-028 Back-to-back transfers SHALL be supported at one word per cycle when out_ready stays 1.
REQ-029 out_last SHALL be 1 only on the highest-index unmasked word; its transfer SHALL return the FSM to IDLE on the next cycle.
REQ-030 Deasserting enable mid-event SHALL NOT abort the event; the event SHALL complete normally.
REQ-031 A trigger arriving in the same cycle as the final READOUT transfer SHALL be dropped; the earliest trigger accepted after an event SHALL be one in the first IDLE cycle.
REQ-032 busy SHALL be a registered output equal to (state != IDLE).

Reset
REQ-033 rst=1 SHALL asynchronously force state=IDLE, l0_out=0, busy=0, out_valid=0, out_last=0, out_data=0, out_ch=0, evt_cnt=0, drop_cnt=0, and the wait counter and capture registers to 0.
REQ-034 Reset asserted mid-event SHALL abandon that event with no further words output; after release the block SHALL accept a new trigger in the first clock cycle.

Structure
REQ-035 The state enum and the WAIT computation helper SHALL live in a shared package, sample_sum_pkg.
REQ-036 The masked next-channel search SHALL be one sub-module, ch_next_sel: it takes the mask and the current index and returns the next unmasked index and a last flag.

Verification
REQ-037 N_CH=4, mask=4'b1111, ch_data={10,20,30,40}, l0_in at t0: l0_out at t0+1, capture 27 cycles later, words (0,10),(1,20),(2,30),(3,40) with out_last on ch3, evt_cnt=1.
REQ-038 mask=4'b1010, out_ready toggling 1/0: only ch1 and ch3 are output; data is stable during stalls; out_last is on ch3.
REQ-039 mask=0: l0_out pulses, busy lasts the WAIT window, no out_valid, evt_cnt increments.
REQ-040 Second l0_in 5 cycles after the first, plus l0_in with enable=0: drop_cnt=2, a single l0_out, evt_cnt=1.
REQ-041 rst asserted during READOUT after 2 words: outputs clear immediately; a new trigger 1 cycle after release is accepted.
